mem_request_queue: RTL and testbench
====================================

# mem_request_queue

Request buffer and sequencer that sits directly upstream of a main-memory port. Accepts read and write-back requests from the cache side on a valid/ready handshake, queues them in a small FIFO, and issues them one at a time to main memory using the shared message protocol (NO_REQ / R_REQ / WB_REQ / MEM_RESP from params.h). It returns each completion to the requester on a valid/ready response channel.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDRESS_WIDTH, 32, address width
- MSG_BITS, 4, memory message width; encodings from params.h
- FIFO_DEPTH, 4, request queue entries; power of two, ≥2
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- req_valid  in  1  request present
- req_write  in  1  1 = write-back, 0 = read
- req_address  in  ADDRESS_WIDTH  request address
- req_data  in  DATA_WIDTH  write data; ignored for reads
- req_ready  out  1  queue can accept; equals !full
- resp_valid  out  1  completion available
- resp_write  out  1  completion type
- resp_address  out  ADDRESS_WIDTH  completed address
- resp_data  out  DATA_WIDTH  read data; 0 for writes
- resp_ready  in  1  requester accepts completion
- mem_msg_out  out  MSG_BITS  to memory msg_in
- mem_address_out  out  ADDRESS_WIDTH  to memory address
- mem_data_out  out  DATA_WIDTH  to memory data_in
- mem_msg_in  in  MSG_BITS  from memory msg_out
- mem_data_in  in  DATA_WIDTH  from memory data_out
- count  out  log2(FIFO_DEPTH)+1  queued entries, excluding the entry in flight

## Operation
- Push: on an edge with req_valid && req_ready, write {write, address, data} at the tail. Full means count == FIFO_DEPTH; req_ready is low when full, including on a cycle that also pops. There is no pass-through.
- Pointers: wrap modulo FIFO_DEPTH. count is incremented on push and decremented on pop. Simultaneous push and pop leaves count unchanged.
- FSM states:
  - IDLE: if count != 0, pop the head into the in-flight register, drive mem_msg_out = WB_REQ or R_REQ, mem_address_out and mem_data_out from the entry, and go to REQ. Otherwise stay in IDLE with mem outputs = NO_REQ, 0, 0.
  - REQ: hold mem outputs stable until mem_msg_in == MEM_RESP. On that edge:
    - drive mem_msg_out = NO_REQ and mem address/data = 0;
    - load resp_* (resp_data = mem_data_in for reads, 0 for writes);
    - set resp_valid = 1;
    - go to RESP.
  - RESP: hold resp_* until resp_ready. On the resp_valid && resp_ready edge, clear resp_valid and go to IDLE. mem_msg_out stays NO_REQ throughout RESP.
- The NO_REQ gap of ≥1 cycle between consecutive requests is mandatory. It prevents memory from re-accepting a held request.
- MEM_RESP is ignored in IDLE and RESP; it causes no state change.
- Reset (reset == 0 at an edge) applies from any state:
  - FIFO is flushed: pointers and count = 0.
  - state = IDLE; any in-flight transaction is abandoned.
  - Outputs: req_ready = 0 during reset, resp_valid = 0, resp_* = 0, mem_msg_out = NO_REQ, mem address/data = 0.
  - Memory shares the reset event at top level.
- req_ready = 1 from the first edge after reset is released.

## Timing
- All outputs are registered except req_ready, which is combinational from count and reset.
- Read, with the memory latency of IDLE→SERVING→READ_OUT:
  - push at edge E0;
  - R_REQ is driven after E1;
  - memory accepts at E2;
  - MEM_RESP and data are visible after E3;
  - resp_valid = 1 after E4.
- Write: push at E0, WB_REQ after E1, MEM_RESP visible after E2, resp_valid after E3.
- Back-to-back (resp_ready held 1): the next request is issued on the edge after the response handshake. Minimum issue-to-issue spacing is 5 cycles for reads and 4 for writes.
- count updates on the push/pop edge.

## Test plan
- Single read at 0x10 with the memory model holding 0xDEADBEEF → resp_valid rises 4 edges after push; resp_address = 0x10, resp_data = 0xDEADBEEF, resp_write = 0.
- Write 0x12345678 to 0x20, then read 0x20 → write completion has resp_data = 0; read returns 0x12345678; mem_msg_out is NO_REQ for ≥1 cycle between the two requests.
- Push 5 requests with FIFO_DEPTH = 4 while resp_ready = 0:
  - first request enters flight; count reaches 4;
  - req_ready drops after the 5th push and stays 0 until the next pop;
  - completions return in order.
- Hold resp_ready = 0 for 10 cycles during RESP → resp_* stable; mem_msg_out = NO_REQ; no new issue; count unchanged.
- Full queue with simultaneous req_valid and a pop edge → push is refused (req_ready = 0); count goes 4 → 3.
- Assert reset in REQ with 3 entries queued → next cycle: count = 0, mem_msg_out = NO_REQ, resp_valid = 0. After release, req_ready = 1 and a fresh read completes normally.

Source files
------------

// File: rtl/mem_request_queue.sv
// mem_request_queue: FIFO-buffered request sequencer in front of a main-memory port.
//   clock/reset                      : rising-edge clock, synchronous active-low reset
//   req_valid/ready/write/address/data : request push channel (req_ready = !full)
//   resp_valid/ready/write/address/data: completion channel, one per request, in order
//   mem_msg_out/address_out/data_out   : request to memory (NO_REQ / R_REQ / WB_REQ)
//   mem_msg_in/data_in                 : reply from memory (MEM_RESP with read data)
//   count                              : queued entries, excluding the one in flight
module mem_request_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MSG_BITS = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  input  logic                          req_write,
  input  logic [ADDRESS_WIDTH-1:0]      req_address,
  input  logic [DATA_WIDTH-1:0]         req_data,
  output logic                          req_ready,
  output logic                          resp_valid,
  output logic                          resp_write,
  output logic [ADDRESS_WIDTH-1:0]      resp_address,
  output logic [DATA_WIDTH-1:0]         resp_data,
  input  logic                          resp_ready,
  output logic [MSG_BITS-1:0]           mem_msg_out,
  output logic [ADDRESS_WIDTH-1:0]      mem_address_out,
  output logic [DATA_WIDTH-1:0]         mem_data_out,
  input  logic [MSG_BITS-1:0]           mem_msg_in,
  input  logic [DATA_WIDTH-1:0]         mem_data_in,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [MSG_BITS-1:0] NO_REQ = MSG_BITS'(0);
  localparam logic [MSG_BITS-1:0] R_REQ = MSG_BITS'(1);
  localparam logic [MSG_BITS-1:0] WB_REQ = MSG_BITS'(2);
  localparam logic [MSG_BITS-1:0] MEM_RESP = MSG_BITS'(3);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_next;
  logic [AW-1:0] head, tail;
  logic q_write [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] q_address [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [FIFO_DEPTH];
  logic push, pop;
  logic [MSG_BITS-1:0] mem_msg_d;
  logic [ADDRESS_WIDTH-1:0] mem_address_d, resp_address_d;
  logic [DATA_WIDTH-1:0] mem_data_d, resp_data_d;
  logic resp_valid_d, resp_write_d;
  assign req_ready = reset && count != (AW+1)'(FIFO_DEPTH);
  assign push = req_valid && req_ready;
  always_comb begin
    state_next = state;
    pop = 1'b0;
    mem_msg_d = mem_msg_out;
    mem_address_d = mem_address_out;
    mem_data_d = mem_data_out;
    resp_valid_d = resp_valid;
    resp_write_d = resp_write;
    resp_address_d = resp_address;
    resp_data_d = resp_data;
    case (state)
      IDLE: begin
        pop = count != '0;
        mem_msg_d = pop ? (q_write[head] ? WB_REQ : R_REQ) : NO_REQ;
        mem_address_d = pop ? q_address[head] : '0;
        mem_data_d = pop ? q_data[head] : '0;
        state_next = pop ? REQ : IDLE;
      end
      REQ: if (mem_msg_in == MEM_RESP) begin
        // the in-flight entry lives in the held mem_* outputs
        mem_msg_d = NO_REQ;
        mem_address_d = '0;
        mem_data_d = '0;
        resp_valid_d = 1'b1;
        resp_write_d = mem_msg_out == WB_REQ;
        resp_address_d = mem_address_out;
        resp_data_d = mem_msg_out == WB_REQ ? '0 : mem_data_in;
        state_next = RESP;
      end
      RESP: if (resp_ready) begin
        resp_valid_d = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      head <= '0;
      tail <= '0;
      count <= '0;
      mem_msg_out <= NO_REQ;
      mem_address_out <= '0;
      mem_data_out <= '0;
      resp_valid <= 1'b0;
      resp_write <= 1'b0;
      resp_address <= '0;
      resp_data <= '0;
    end else begin
      state <= state_next;
      head <= head + AW'(pop);
      tail <= tail + AW'(push);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      mem_msg_out <= mem_msg_d;
      mem_address_out <= mem_address_d;
      mem_data_out <= mem_data_d;
      resp_valid <= resp_valid_d;
      resp_write <= resp_write_d;
      resp_address <= resp_address_d;
      resp_data <= resp_data_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) begin
      q_write[tail] <= req_write;
      q_address[tail] <= req_address;
      q_data[tail] <= req_data;
    end
  end
endmodule

// File: tb/tb_mem_request_queue.sv
// tb_mem_request_queue: scoreboard bench for mem_request_queue with a behavioural memory.
module tb_mem_request_queue;
  localparam logic [3:0] NO_REQ = 4'd0;
  localparam logic [3:0] R_REQ = 4'd1;
  localparam logic [3:0] WB_REQ = 4'd2;
  localparam logic [3:0] MEM_RESP = 4'd3;
  typedef struct packed {logic w; logic [31:0] a; logic [31:0] d;} txn_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_address = '0, req_data = '0;
  logic req_ready;
  logic resp_valid, resp_write;
  logic [31:0] resp_address, resp_data;
  logic resp_ready = 1'b0;
  logic [3:0] mem_msg_out, mem_msg_in;
  logic [31:0] mem_address_out, mem_data_out, mem_data_in;
  logic [2:0] count;
  int checks = 0;
  int errors = 0;
  txn_t sb[$];
  txn_t exp;
  bit [31:0] model_mem [256];
  bit [31:0] ram [256];
  logic [1:0] mst;
  logic [31:0] maddr;

  mem_request_queue dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_address(req_address), .req_data(req_data),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_write(resp_write), .resp_address(resp_address), .resp_data(resp_data),
    .resp_ready(resp_ready),
    .mem_msg_out(mem_msg_out), .mem_address_out(mem_address_out), .mem_data_out(mem_data_out),
    .mem_msg_in(mem_msg_in), .mem_data_in(mem_data_in), .count(count)
  );

  always #5 clock = ~clock;

  // memory: IDLE accepts, SERVING adds a cycle for reads, READ_OUT presents MEM_RESP one cycle
  always @(posedge clock) begin
    if (!reset) begin
      mst <= 2'd0;
      maddr <= '0;
      mem_msg_in <= NO_REQ;
      mem_data_in <= '0;
      for (int i = 0; i < 256; i++) ram[i] <= '0;
      ram[4] <= 32'hDEADBEEF;
    end else begin
      case (mst)
        2'd0: begin
          if (mem_msg_out == R_REQ) begin
            mst <= 2'd1;
            maddr <= mem_address_out;
          end else if (mem_msg_out == WB_REQ) begin
            ram[mem_address_out[9:2]] <= mem_data_out;
            mem_msg_in <= MEM_RESP;
            mst <= 2'd2;
          end
        end
        2'd1: begin
          mem_msg_in <= MEM_RESP;
          mem_data_in <= ram[maddr[9:2]];
          mst <= 2'd2;
        end
        default: begin
          mem_msg_in <= NO_REQ;
          mem_data_in <= '0;
          mst <= 2'd0;
        end
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic push_req(input logic w, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_address = a;
    req_data = d;
    if (req_ready) begin
      if (w) model_mem[a[9:2]] = d;
      sb.push_back('{w, a, w ? 32'h0 : model_mem[a[9:2]]});
    end
    tick;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_address = '0;
    req_data = '0;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 60) begin
      tick;
      n++;
    end
  endtask

  task automatic test_reset;
    model_mem[4] = 32'hDEADBEEF;
    reset = 1'b0;
    tick;
    tick;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    checks++;
    if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++;
    if ({resp_valid, resp_write, resp_address, resp_data} !== 66'd0) begin
      errors++; $display("FAIL reset_resp got %b %b %h %h want zeros", resp_valid, resp_write, resp_address, resp_data);
    end
    checks++;
    if ({mem_msg_out, mem_address_out, mem_data_out} !== {NO_REQ, 64'd0}) begin
      errors++; $display("FAIL reset_mem got %h %h %h want NO_REQ 0 0", mem_msg_out, mem_address_out, mem_data_out);
    end
    reset = 1'b1;
    tick;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL release_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_single_read;
    int n;
    resp_ready = 1'b1;
    push_req(1'b0, 32'h10, 32'h0);
    checks++;
    if (count !== 3'd1) begin errors++; $display("FAIL read_count_push got %0d want 1", count); end
    tick;
    checks++;
    if ({mem_msg_out, mem_address_out, count} !== {R_REQ, 32'h10, 3'd0}) begin
      errors++; $display("FAIL read_issue got %h %h %0d want %h 10 0", mem_msg_out, mem_address_out, count, R_REQ);
    end
    wait_resp(n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL read_latency got %0d want 3 (4 edges after push)", n + 1); end
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL read_resp_extra got %h %h", resp_address, resp_data);
    end else begin
      exp = sb.pop_front();
      if ({resp_write, resp_address, resp_data} !== exp) begin
        errors++; $display("FAIL read_resp got %b %h %h want %b %h %h", resp_write, resp_address, resp_data, exp.w, exp.a, exp.d);
      end
    end
    tick;
    checks++;
    if ({resp_valid, mem_msg_out} !== {1'b0, NO_REQ}) begin
      errors++; $display("FAIL read_handshake got %b %h want 0 %h", resp_valid, mem_msg_out, NO_REQ);
    end
  endtask

  task automatic test_write_read;
    int issues, nresp;
    logic [3:0] prev;
    resp_ready = 1'b1;
    push_req(1'b1, 32'h20, 32'h12345678);
    push_req(1'b0, 32'h20, 32'h0);
    issues = 0;
    nresp = 0;
    prev = NO_REQ;
    for (int i = 0; i < 16; i++) begin
      if (mem_msg_out != NO_REQ && prev == NO_REQ) issues++;
      prev = mem_msg_out;
      if (resp_valid) begin
        nresp++;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL wr_resp_extra got %h %h", resp_address, resp_data);
        end else begin
          exp = sb.pop_front();
          if ({resp_write, resp_address, resp_data} !== exp) begin
            errors++; $display("FAIL wr_resp got %b %h %h want %b %h %h", resp_write, resp_address, resp_data, exp.w, exp.a, exp.d);
          end
        end
      end
      tick;
    end
    checks++;
    if (issues !== 2) begin errors++; $display("FAIL wr_noreq_gap got %0d issues want 2", issues); end
    checks++;
    if (nresp !== 2) begin errors++; $display("FAIL wr_resp_count got %0d want 2", nresp); end
  endtask

  task automatic test_fill_hold;
    int n;
    logic ok;
    logic [64:0] snap;
    resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_req(i % 2 == 1, 32'h100 + 32'(i) * 4, 32'hA000 + 32'(i));
    checks++;
    if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", count); end
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL fill_req_ready got %b want 0", req_ready); end
    wait_resp(n);
    checks++;
    if (n >= 60) begin errors++; $display("FAIL fill_resp_timeout got %0d cycles want <60", n); end
    snap = {resp_write, resp_address, resp_data};
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (!resp_valid || {resp_write, resp_address, resp_data} !== snap || mem_msg_out !== NO_REQ || count !== 3'd4 || req_ready !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL hold_stable got %b %h %h msg %h count %0d want stable", resp_valid, resp_address, resp_data, mem_msg_out, count);
    end
  endtask

  task automatic test_full_pop;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_address = 32'h999;
    req_data = 32'h55;
    resp_ready = 1'b1;
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL full_resp_extra got %h %h", resp_address, resp_data);
    end else begin
      exp = sb.pop_front();
      if ({resp_write, resp_address, resp_data} !== exp) begin
        errors++; $display("FAIL full_resp got %b %h %h want %b %h %h", resp_write, resp_address, resp_data, exp.w, exp.a, exp.d);
      end
    end
    tick;
    checks++;
    if ({count, req_ready} !== {3'd4, 1'b0}) begin errors++; $display("FAIL full_after_hs got %0d %b want 4 0", count, req_ready); end
    tick;
    req_valid = 1'b0;
    checks++;
    if (count !== 3'd3) begin errors++; $display("FAIL full_pop_count got %0d want 3", count); end
    checks++;
    if (mem_msg_out !== WB_REQ) begin errors++; $display("FAIL full_pop_issue got %h want %h", mem_msg_out, WB_REQ); end
    for (int i = 0; i < 80 && sb.size() > 0; i++) begin
      if (resp_valid) begin
        checks++;
        exp = sb.pop_front();
        if ({resp_write, resp_address, resp_data} !== exp) begin
          errors++; $display("FAIL drain_resp got %b %h %h want %b %h %h", resp_write, resp_address, resp_data, exp.w, exp.a, exp.d);
        end
      end
      tick;
    end
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL drain_pending got %0d want 0", sb.size()); end
    repeat (8) tick;
    checks++;
    if ({count, resp_valid} !== {3'd0, 1'b0}) begin errors++; $display("FAIL drain_idle got %0d %b want 0 0", count, resp_valid); end
  endtask

  task automatic test_reset_in_req;
    int n;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_req(1'b0, 32'h30 + 32'(i) * 4, 32'h0);
    checks++;
    if ({count, mem_msg_out} !== {3'd3, R_REQ}) begin errors++; $display("FAIL rreq_setup got %0d %h want 3 %h", count, mem_msg_out, R_REQ); end
    reset = 1'b0;
    tick;
    sb.delete();
    checks++;
    if ({count, mem_msg_out, resp_valid, req_ready} !== {3'd0, NO_REQ, 2'b00}) begin
      errors++; $display("FAIL rreq_flush got %0d %h %b %b want 0 %h 0 0", count, mem_msg_out, resp_valid, req_ready, NO_REQ);
    end
    reset = 1'b1;
    tick;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rreq_release got %b want 1", req_ready); end
    push_req(1'b0, 32'h10, 32'h0);
    wait_resp(n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL rreq_latency got %0d want 4", n); end
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL rreq_resp_extra got %h %h", resp_address, resp_data);
    end else begin
      exp = sb.pop_front();
      if ({resp_write, resp_address, resp_data} !== exp) begin
        errors++; $display("FAIL rreq_resp got %b %h %h want %b %h %h", resp_write, resp_address, resp_data, exp.w, exp.a, exp.d);
      end
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_write_read;
    test_fill_hold;
    test_full_pop;
    test_reset_in_req;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
